icache: RTL and testbench

ICACHE -- requirements
Module: icache

---
 rtl/icache_pkg.sv | 14 +
 rtl/icache_ram.sv | 36 +++
 rtl/icache.sv | 158 +++++++++++++++
 tb/tb_icache.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared types and default geometry for the direct-mapped instruction cache.
package icache_pkg;

  localparam int unsigned DefLines     = 16;
  localparam int unsigned DefLineWords = 4;

  typedef enum logic [1:0] {
    StIdle,
    StLookup,
    StRefill,
    StResp
  } state_e;

endpackage

// File: rtl/icache_ram.sv
// Tag and data storage for the instruction cache: asynchronous read, synchronous word write.
module icache_ram #(
  parameter int unsigned LINES      = 16,
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned IdxW       = $clog2(LINES),
  parameter int unsigned WordAw     = $clog2(LINES * LINE_WORDS),
  parameter int unsigned TagW       = 24
) (
  input  logic              clk_i,
  input  logic [IdxW-1:0]   idx_i,
  input  logic [WordAw-1:0] rd_word_i,
  output logic [31:0]       rd_data_o,
  output logic [TagW-1:0]   rd_tag_o,
  input  logic              wr_en_i,
  input  logic [WordAw-1:0] wr_word_i,
  input  logic [31:0]       wr_data_i,
  input  logic              tag_we_i,
  input  logic [TagW-1:0]   tag_wdata_i
);

  logic [31:0]     data_mem [LINES*LINE_WORDS];
  logic [TagW-1:0] tag_mem  [LINES];

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      data_mem[wr_word_i] <= wr_data_i;
    end
    if (tag_we_i) begin
      tag_mem[idx_i] <= tag_wdata_i;
    end
  end

  assign rd_data_o = data_mem[rd_word_i];
  assign rd_tag_o  = tag_mem[idx_i];

endmodule

// File: rtl/icache.sv
// Direct-mapped instruction cache with whole-line refill and fence.i flush.
module icache
  import icache_pkg::*;
#(
  parameter int unsigned LINES      = DefLines,
  parameter int unsigned LINE_WORDS = DefLineWords
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        fe_req,
  input  logic [31:0] fe_addr,
  output logic        fe_ack,
  output logic [31:0] fe_data,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_data
);

  localparam int unsigned OfsW   = $clog2(LINE_WORDS);
  localparam int unsigned IdxW   = $clog2(LINES);
  localparam int unsigned TagW   = 30 - OfsW - IdxW;
  localparam int unsigned CntW   = (OfsW == 0) ? 1 : OfsW;
  localparam int unsigned WordAw = OfsW + IdxW;
  localparam logic [31:0] LineMask = 32'(LINE_WORDS * 4 - 1);

  state_e           state_q, state_d;
  logic [31:0]      addr_q;
  logic [LINES-1:0] valid_q;
  logic [CntW-1:0]  cnt_q;
  logic             flushed_q;
  logic             dropped_q;

  logic [IdxW-1:0]   idx;
  logic [TagW-1:0]   tag;
  logic [WordAw-1:0] rd_word;
  logic [WordAw-1:0] wr_word;
  logic [31:0]       line_base;
  logic [31:0]       refill_addr;
  logic [31:0]       rd_data;
  logic [TagW-1:0]   rd_tag;
  logic              hit;
  logic              last_word;
  logic              fill_wr;
  logic              fill_done;

  // Arithmetic slicing keeps LINE_WORDS == 1 free of zero-width ranges.
  assign idx         = IdxW'(addr_q >> (2 + OfsW));
  assign tag         = TagW'(addr_q >> (2 + OfsW + IdxW));
  assign rd_word     = WordAw'(addr_q >> 2);
  assign line_base   = addr_q & ~LineMask;
  assign wr_word     = WordAw'(line_base >> 2) + WordAw'(cnt_q);
  assign refill_addr = line_base | (32'(cnt_q) << 2);

  assign hit       = valid_q[idx] && (rd_tag == tag);
  assign last_word = (cnt_q == CntW'(LINE_WORDS - 1));
  assign fill_wr   = (state_q == StRefill) && mem_ack;
  assign fill_done = fill_wr && last_word;

  icache_ram #(
    .LINES      (LINES),
    .LINE_WORDS (LINE_WORDS),
    .IdxW       (IdxW),
    .WordAw     (WordAw),
    .TagW       (TagW)
  ) u_ram (
    .clk_i       (clk),
    .idx_i       (idx),
    .rd_word_i   (rd_word),
    .rd_data_o   (rd_data),
    .rd_tag_o    (rd_tag),
    .wr_en_i     (fill_wr),
    .wr_word_i   (wr_word),
    .wr_data_i   (mem_data),
    .tag_we_i    (fill_done),
    .tag_wdata_i (tag)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      valid_q   <= '0;
      cnt_q     <= '0;
      flushed_q <= 1'b0;
      dropped_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && fe_req) begin
        addr_q <= fe_addr;
      end
      if (state_q == StLookup) begin
        cnt_q     <= '0;
        flushed_q <= 1'b0;
        dropped_q <= 1'b0;
      end else if (state_q == StRefill) begin
        if (fill_done) begin
          cnt_q <= '0;
        end else if (mem_ack) begin
          cnt_q <= cnt_q + CntW'(1);
        end
        if (flush) begin
          flushed_q <= 1'b1;
        end
        if (!fe_req) begin
          dropped_q <= 1'b1;
        end
      end
      // A flush anywhere in the refill window keeps the new line invalid.
      if (flush) begin
        valid_q <= '0;
      end else if (fill_done && !flushed_q) begin
        valid_q[idx] <= 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (fe_req) state_d = StLookup;
      StLookup: state_d = hit ? StIdle : StRefill;
      StRefill: begin
        if (fill_done) begin
          state_d = (fe_req && !dropped_q) ? StResp : StIdle;
        end
      end
      StResp:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    fe_ack   = 1'b0;
    fe_data  = '0;
    mem_req  = 1'b0;
    mem_addr = '0;
    unique case (state_q)
      StLookup: begin
        if (hit) begin
          fe_ack  = 1'b1;
          fe_data = rd_data;
        end
      end
      StRefill: begin
        mem_req  = 1'b1;
        mem_addr = refill_addr;
      end
      StResp: begin
        fe_ack  = 1'b1;
        fe_data = rd_data;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_icache.sv
// Randomized scoreboard bench for icache against a line-level valid/tag model.
module tb_icache;

  localparam int LINES      = 16;
  localparam int LINE_WORDS = 4;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        fe_req;
  logic [31:0] fe_addr;
  logic        fe_ack;
  logic [31:0] fe_data;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_data;

  icache #(
    .LINES      (LINES),
    .LINE_WORDS (LINE_WORDS)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .fe_req   (fe_req),
    .fe_addr  (fe_addr),
    .fe_ack   (fe_ack),
    .fe_data  (fe_data),
    .mem_req  (mem_req),
    .mem_addr (mem_addr),
    .mem_ack  (mem_ack),
    .mem_data (mem_data)
  );

  typedef struct {
    logic [31:0] data;
    bit          hit;
    int          cyc;
  } exp_t;

  exp_t        exp_fe[$];
  logic [31:0] exp_mem[$];

  bit mvalid [LINES];
  int mtag   [LINES];

  int checks   = 0;
  int failures = 0;
  int cyc_cnt  = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc_cnt);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < LINES; i++) mvalid[i] = 1'b0;
  endtask

  // Monitor: every acknowledged fetch and every accepted refill word is matched here.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (fe_ack) begin
        if (exp_fe.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_fe_ack: got data %08h expected no ack", fe_data);
        end else begin
          e = exp_fe.pop_front();
          chk("fe_data", fe_data, e.data);
          if (e.hit) chk("hit_latency", 32'(cyc_cnt), 32'(e.cyc + 1));
          else chk("refill_words_left", 32'(exp_mem.size()), 32'd0);
        end
        chk("ack_with_mem_req", {31'd0, mem_req}, 32'd0);
      end else begin
        chk("fe_data_idle", fe_data, 32'd0);
      end
      if (!mem_req) chk("mem_addr_idle", mem_addr, 32'd0);
      if (mem_req && mem_ack) begin
        if (exp_mem.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_refill: got addr %08h expected no refill", mem_addr);
        end else begin
          chk("mem_addr", mem_addr, exp_mem.pop_front());
        end
      end
    end
  end

  task automatic pulse_flush();
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    model_clear();
    cyc();
  endtask

  // mode: 0 plain, 1 flush at refill ack #when, 2 drop fe_req at ack #when,
  // 3 reset after ack #when, 4 flush in the lookup cycle.
  task automatic access(input logic [31:0] addr, input int mode, input int when);
    int   idx, tg, acks;
    bit   hit, done, flushed;
    exp_t e;
    logic [31:0] base;
    idx  = int'((addr >> 4) % LINES);
    tg   = int'(addr >> 8);
    hit  = mvalid[idx] && (mtag[idx] == tg);
    base = addr & ~32'hF;
    if (hit && (mode == 1 || mode == 2 || mode == 3)) mode = 0;
    if (!hit) begin
      for (int w = 0; w < LINE_WORDS; w++) exp_mem.push_back(base + 32'(4 * w));
    end
    if (mode != 2 && mode != 3) begin
      e.data = memfn(addr & ~32'h3);
      e.hit  = hit;
      e.cyc  = cyc_cnt;
      exp_fe.push_back(e);
    end
    fe_req  = 1'b1;
    fe_addr = addr;
    acks    = 0;
    done    = 1'b0;
    flushed = 1'b0;
    for (int n = 0; n < 400 && !done; n++) begin
      mem_ack  = 1'b0;
      mem_data = '0;
      flush    = 1'b0;
      if (mode == 4 && n == 1) flush = 1'b1;
      if (fe_ack) begin
        done   = 1'b1;
        fe_req = 1'b0;
      end else if (mem_req && $urandom_range(1, 0) == 1) begin
        mem_ack  = 1'b1;
        mem_data = memfn(mem_addr);
        acks++;
        if (mode == 1 && acks == when) begin
          flush   = 1'b1;
          flushed = 1'b1;
        end
        if (mode == 2 && acks == when) fe_req = 1'b0;
      end
      cyc();
      if ((mode == 2 && acks == LINE_WORDS) || (mode == 3 && acks == when)) done = 1'b1;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL timeout: addr %08h mode %0d got no completion expected fe_ack", addr, mode);
    end
    fe_req   = 1'b0;
    mem_ack  = 1'b0;
    mem_data = '0;
    flush    = 1'b0;
    if (mode == 3) begin
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      chk("rst_fe_ack", {31'd0, fe_ack}, 32'd0);
      chk("rst_fe_data", fe_data, 32'd0);
      chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      exp_mem.delete();
      exp_fe.delete();
      model_clear();
      mem_ack  = 1'b1;
      mem_data = 32'hDEAD_BEEF;
      cyc();
      mem_ack  = 1'b0;
      mem_data = '0;
    end else begin
      if (mode == 4 || flushed) model_clear();
      if (!hit && !flushed) begin
        mvalid[idx] = 1'b1;
        mtag[idx]   = tg;
      end
    end
    cyc();
  endtask

  initial begin
    int r, mode, when;
    logic [31:0] a;
    reset   = 1'b1;
    flush   = 1'b0;
    fe_req  = 1'b0;
    fe_addr = '0;
    mem_ack = 1'b0;
    mem_data = '0;
    model_clear();
    for (int i = 0; i < LINES; i++) mtag[i] = 0;
    cyc();
    cyc();
    chk("reset_fe_ack", {31'd0, fe_ack}, 32'd0);
    chk("reset_fe_data", fe_data, 32'd0);
    chk("reset_mem_req", {31'd0, mem_req}, 32'd0);
    chk("reset_mem_addr", mem_addr, 32'd0);
    reset = 1'b0;
    cyc();

    access(32'h0000_0104, 0, 0);   // cold miss
    access(32'h0000_0108, 0, 0);   // hit
    access(32'h0000_0204, 0, 0);   // conflict on index 0
    access(32'h0000_0104, 0, 0);   // evicted, misses again
    access(32'h0000_0104, 0, 0);   // hit
    pulse_flush();
    access(32'h0000_0104, 0, 0);   // refill after flush
    access(32'h0000_0304, 1, 2);   // flush on second refill ack
    access(32'h0000_0304, 0, 0);   // line was not installed
    access(32'h0000_0404, 3, 2);   // reset mid-refill
    access(32'h0000_0404, 0, 0);   // full refill afterwards
    access(32'h0000_0514, 2, 1);   // requester drops during refill
    access(32'h0000_0518, 0, 0);   // dropped refill still installed
    access(32'h0000_0518, 4, 0);   // flush during a hitting lookup
    access(32'h0000_051C, 0, 0);   // flushed, so refills

    for (int i = 0; i < 300; i++) begin
      a = (32'($urandom_range(3, 0)) << 8) | (32'($urandom_range(15, 0)) << 4)
        | (32'($urandom_range(3, 0)) << 2) | 32'($urandom_range(3, 0));
      r = int'($urandom_range(99, 0));
      when = int'($urandom_range(4, 1));
      if (r < 64) mode = 0;
      else if (r < 72) mode = 1;
      else if (r < 80) mode = 2;
      else if (r < 86) begin
        mode = 3;
        when = int'($urandom_range(3, 1));
      end else if (r < 94) mode = 4;
      else begin
        pulse_flush();
        mode = 0;
      end
      access(a, mode, when);
    end

    repeat (3) cyc();
    chk("fe_queue_drained", 32'(exp_fe.size()), 32'd0);
    chk("mem_queue_drained", 32'(exp_mem.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
